// File: rtl/uart_rx_cmd_parser.sv
// Command-frame parser behind the UART receiver: decodes write/read/ALU frames into one-cycle strobes.
// Optional inter-byte timeout abort enabled by defining RX_CMD_TIMEOUT_EN.
module uart_rx_cmd_parser #(
   parameter int ADDR_W      = 4,
   parameter int FUN_W       = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_err,
   output logic              rf_wr_en,
   output logic              rf_rd_en,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [7:0]        rf_wr_data,
   output logic              alu_en,
   output logic [FUN_W-1:0]  alu_fun,
   output logic              frame_done,
   output logic              cmd_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_OPA, S_ALU_OPB, S_ALU_FUN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              rf_wr_en_q, rf_wr_en_d;
   logic              rf_rd_en_q, rf_rd_en_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [7:0]        rf_wr_data_q, rf_wr_data_d;
   logic              alu_en_q, alu_en_d;
   logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
   logic              frame_done_q, frame_done_d;
   logic              cmd_err_q, cmd_err_d;
   logic              expire;

`ifdef RX_CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts idle cycles mid-frame; any received byte or abort restarts it.
   always_comb begin
      cnt_d  = '0;
      expire = 1'b0;
      if (!rx_valid && !rx_err && state_q != S_IDLE) begin
         if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) expire = 1'b1;
         else                                  cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      rf_wr_en_d   = 1'b0;
      rf_rd_en_d   = 1'b0;
      rf_addr_d    = rf_addr_q;
      rf_wr_data_d = rf_wr_data_q;
      alu_en_d     = 1'b0;
      alu_fun_d    = alu_fun_q;
      frame_done_d = 1'b0;
      cmd_err_d    = 1'b0;
      if (rx_err) begin
         cmd_err_d = 1'b1;
         state_d   = S_IDLE;
      end else if (rx_valid) begin
         case (state_q)
            S_IDLE: begin
               case (rx_data)
                  8'hAA:   state_d = S_WR_ADDR;
                  8'hBB:   state_d = S_RD_ADDR;
                  8'hCC:   state_d = S_ALU_OPA;
                  8'hDD:   state_d = S_ALU_FUN;
                  default: cmd_err_d = 1'b1;
               endcase
            end
            S_WR_ADDR: begin
               wr_addr_d = rx_data[ADDR_W-1:0];
               state_d   = S_WR_DATA;
            end
            S_WR_DATA: begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = wr_addr_q;
               rf_wr_data_d = rx_data;
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end
            S_RD_ADDR: begin
               rf_rd_en_d   = 1'b1;
               rf_addr_d    = rx_data[ADDR_W-1:0];
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end
            // Operands land in fixed registers 0 and 1 ahead of the ALU launch.
            S_ALU_OPA: begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = ADDR_W'(0);
               rf_wr_data_d = rx_data;
               state_d      = S_ALU_OPB;
            end
            S_ALU_OPB: begin
               rf_wr_en_d   = 1'b1;
               rf_addr_d    = ADDR_W'(1);
               rf_wr_data_d = rx_data;
               state_d      = S_ALU_FUN;
            end
            S_ALU_FUN: begin
               alu_en_d     = 1'b1;
               alu_fun_d    = rx_data[FUN_W-1:0];
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (expire) begin
         cmd_err_d = 1'b1;
         state_d   = S_IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         wr_addr_q    <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_rd_en_q   <= 1'b0;
         rf_addr_q    <= '0;
         rf_wr_data_q <= 8'h00;
         alu_en_q     <= 1'b0;
         alu_fun_q    <= '0;
         frame_done_q <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_rd_en_q   <= rf_rd_en_d;
         rf_addr_q    <= rf_addr_d;
         rf_wr_data_q <= rf_wr_data_d;
         alu_en_q     <= alu_en_d;
         alu_fun_q    <= alu_fun_d;
         frame_done_q <= frame_done_d;
         cmd_err_q    <= cmd_err_d;
      end
   end

   assign rf_wr_en   = rf_wr_en_q;
   assign rf_rd_en   = rf_rd_en_q;
   assign rf_addr    = rf_addr_q;
   assign rf_wr_data = rf_wr_data_q;
   assign alu_en     = alu_en_q;
   assign alu_fun    = alu_fun_q;
   assign frame_done = frame_done_q;
   assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Bench for uart_rx_cmd_parser: directed frames plus random byte stream against a frame-buffer model.
module tb_uart_rx_cmd_parser;

   localparam int TO = 16;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_err = 1'b0;
   logic       rf_wr_en, rf_rd_en, alu_en, frame_done, cmd_err;
   logic [3:0] rf_addr, alu_fun;
   logic [7:0] rf_wr_data;

   int total = 0;
   int bad   = 0;

   uart_rx_cmd_parser #(.ADDR_W(4), .FUN_W(4), .TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
      .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
      .alu_en(alu_en), .alu_fun(alu_fun), .frame_done(frame_done), .cmd_err(cmd_err)
   );

   always #5 CLK = ~CLK;

   // Reference model: bytes of the frame in progress plus last driven output values.
   logic [7:0] fq[$];
   int         idle_cnt = 0;
   logic       e_wr, e_rd, e_alu, e_done, e_err;
   logic [3:0] e_addr = 4'h0, e_fun = 4'h0;
   logic [7:0] e_wdata = 8'h00;

   task automatic model(input logic v, input logic [7:0] d, input logic e, input logic r);
      logic [7:0] b1, b2, b3;
      {e_wr, e_rd, e_alu, e_done, e_err} = 5'b0;
      if (r) begin
         fq.delete(); idle_cnt = 0;
         e_addr = 4'h0; e_fun = 4'h0; e_wdata = 8'h00;
      end else if (e) begin
         e_err = 1'b1; fq.delete(); idle_cnt = 0;
      end else if (v) begin
         idle_cnt = 0;
         fq.push_back(d);
         b1 = (fq.size() > 1) ? fq[1] : 8'h00;
         b2 = (fq.size() > 2) ? fq[2] : 8'h00;
         b3 = (fq.size() > 3) ? fq[3] : 8'h00;
         case (fq[0])
            8'hAA: if (fq.size() == 3) begin
               e_wr = 1'b1; e_addr = b1[3:0]; e_wdata = b2; e_done = 1'b1; fq.delete();
            end
            8'hBB: if (fq.size() == 2) begin
               e_rd = 1'b1; e_addr = b1[3:0]; e_done = 1'b1; fq.delete();
            end
            8'hCC: begin
               if (fq.size() == 2) begin e_wr = 1'b1; e_addr = 4'd0; e_wdata = b1; end
               if (fq.size() == 3) begin e_wr = 1'b1; e_addr = 4'd1; e_wdata = b2; end
               if (fq.size() == 4) begin e_alu = 1'b1; e_fun = b3[3:0]; e_done = 1'b1; fq.delete(); end
            end
            8'hDD: if (fq.size() == 2) begin
               e_alu = 1'b1; e_fun = b1[3:0]; e_done = 1'b1; fq.delete();
            end
            default: begin e_err = 1'b1; fq.delete(); end
         endcase
      end else if (fq.size() != 0) begin
`ifdef RX_CMD_TIMEOUT_EN
         idle_cnt++;
         if (idle_cnt == TO) begin e_err = 1'b1; fq.delete(); idle_cnt = 0; end
`endif
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic e, input logic r);
      rx_valid = v; rx_data = d; rx_err = e; RST = r;
      @(posedge CLK);
      model(v, d, e, r);
      #1;
      check("strobes", {27'd0, rf_wr_en, rf_rd_en, alu_en, frame_done, cmd_err},
            {27'd0, e_wr, e_rd, e_alu, e_done, e_err});
      check("rf_addr", {28'd0, rf_addr}, {28'd0, e_addr});
      check("rf_wr_data", {24'd0, rf_wr_data}, {24'd0, e_wdata});
      check("alu_fun", {28'd0, alu_fun}, {28'd0, e_fun});
      rx_valid = 1'b0; rx_err = 1'b0; RST = 1'b0;
   endtask

   task automatic byte_in(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      int k;
      logic [7:0] b;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      idle(1);

      // Write frame, with explicit constant cross-checks on the final strobe
      byte_in(8'hAA); byte_in(8'h05); byte_in(8'h3C);
      check("wr_const", {21'd0, rf_wr_en, frame_done, rf_addr, rf_wr_data}, {21'd0, 1'b1, 1'b1, 4'h5, 8'h3C});
      idle(2);

      // ALU with operands, back-to-back
      byte_in(8'hCC); byte_in(8'h12); byte_in(8'h34); byte_in(8'h02);
      check("alu_const", {26'd0, alu_en, frame_done, alu_fun}, {26'd0, 1'b1, 1'b1, 4'h2});
      idle(1);

      byte_in(8'hBB); byte_in(8'h0F); idle(1);
      byte_in(8'hDD); byte_in(8'h07); idle(1);
      byte_in(8'h55); byte_in(8'hBB); byte_in(8'h03); idle(1);

      // rx_err abort mid-frame, and rx_err colliding with a valid byte in IDLE
      byte_in(8'hAA); byte_in(8'h02); step(1'b0, 8'h00, 1'b1, 1'b0); idle(1);
      step(1'b1, 8'hAA, 1'b1, 1'b0); byte_in(8'h09); idle(1);

      // Reset mid-frame discards it silently
      byte_in(8'hCC); byte_in(8'h11); step(1'b0, 8'h00, 1'b0, 1'b1); idle(1);
      byte_in(8'h44); byte_in(8'h3A); idle(1);

      // Stall mid-frame for TO cycles, then a frame whose second byte arrives on the last allowed cycle
      byte_in(8'hAA); idle(TO); byte_in(8'h05); byte_in(8'h3C); idle(1);
      byte_in(8'hAA); idle(TO - 1); byte_in(8'h06); byte_in(8'h7E); idle(2);
      byte_in(8'hDD); idle(TO + 3); byte_in(8'h0B); idle(1);

      // Random stream biased toward valid opcodes
      for (int i = 0; i < 600; i++) begin
         k = $urandom_range(0, 99);
         case ($urandom_range(0, 3))
            0:       b = 8'hAA + 8'(17 * $urandom_range(0, 3));
            default: b = 8'($urandom);
         endcase
         if (k < 60)      byte_in(b);
         else if (k < 63) step(1'b0, 8'h00, 1'b1, 1'b0);
         else if (k < 65) step($urandom_range(0, 1) == 1, b, 1'b1, 1'b0);
         else if (k < 66) step(1'b0, 8'h00, 1'b0, 1'b1);
         else if (k < 68) idle($urandom_range(10, 20));
         else             idle(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
